fpga_srl_fifo: RTL and testbench
================================

Name: fpga_srl_fifo

Overview:
- Synchronous FIFO controller built around one internal fpga_srl instance (shift-register storage) plus a one-entry registered output stage.
- Owns the SRL write-enable and read-address sequencing. Exposes valid/ready handshakes on both sides, plus occupancy and almost-full status.
- Used wherever a shallow, LUT-cheap elastic buffer is needed between pipeline stages of eduSOC datapaths.

Parameters:
- DWIDTH, 32: data width, passed to fpga_srl.
- AWIDTH, 5: SRL address width, passed to fpga_srl.
- DEPTH_REDUCTOR, 0: passed to fpga_srl. SRL depth is DEPTH = 2**AWIDTH - DEPTH_REDUCTOR.
- AFULL_THRESH, DEPTH-2: `afull` asserts when `level` >= AFULL_THRESH. Legal range 1..DEPTH+1.

Ports:
- clk  in  1  single clock, rising edge.
- arst  in  1  asynchronous reset, active-high.
- flush  in  1  synchronous clear of all occupancy.
- din  in  DWIDTH  write data.
- din_valid  in  1  write request.
- din_ready  out  1  FIFO can accept a write.
- dout  out  DWIDTH  registered head-of-FIFO data.
- dout_valid  out  1  dout holds valid data.
- dout_ready  in  1  consumer accepts dout.
- level  out  AWIDTH+1  total occupancy: srl_cnt + dout_valid.
- afull  out  1  almost-full flag.
- empty  out  1  level == 0.

Behaviour:
- Interface: one clock, clk; reset arst is asynchronous and active-high.
- Internal state:
  - srl_cnt: 0..DEPTH, number of entries in the SRL.
  - out_vld: drives dout_valid.
  - dout register.
- Total capacity is DEPTH+1.
- Reset (arst=1, immediately, async): srl_cnt=0, out_vld=0, dout=0. Therefore level=0, empty=1, afull=0, din_ready=1. SRL contents are not reset and are don't-care.
- din_ready = (srl_cnt != DEPTH) & ~flush. This is combinational from registered state and flush only; it must not depend on dout_ready.
- wr = din_valid & din_ready. SRL we = wr, SRL din = din. A write shifts all SRL entries up by one and places din at index 0.
- SRL addr = srl_cnt-1 (oldest entry), truncated to AWIDTH; don't-care when srl_cnt=0.
- pop = out_vld & dout_ready.
- load = (srl_cnt != 0) & (~out_vld | pop) & ~flush. On load, dout <= SRL dout_comb at addr srl_cnt-1, sampled before the same-edge shift, and out_vld <= 1.
- If pop & ~load, then out_vld <= 0. dout holds its last value whenever it is not loaded.
- srl_cnt update on a non-flush edge: srl_cnt + wr - load.
  - Simultaneous wr and load: count unchanged. The shift moves the remaining entries so that addr srl_cnt-1 is again the oldest.
- Latency: a write accepted at edge E0 into an empty FIFO gives dout_valid=1 after edge E1 (2-cycle write-to-valid). There is no bypass path.
- Full throughput: with steady state and both sides always ready, 1 word/cycle is sustained.
- flush=1 at an edge: srl_cnt<=0, out_vld<=0. din_ready=0 during that cycle, so no write is accepted. A pop presented in the same cycle is ignored; the word is discarded.
- Full boundary: at srl_cnt=DEPTH, din_ready=0. din_ready rises in the cycle after a load reduces srl_cnt, not in the same cycle.
- Empty boundary: when srl_cnt=0 and out_vld=0, no load occurs and dout is stable.
- Reset mid-transfer: all occupancy is lost immediately. The first post-reset write follows the 2-cycle latency.
- level, afull and empty are combinational from registered state only.
- Ordering: strict FIFO order, with no loss or duplication under any mix of wr, pop and load.
- Assertions for the bench:
  - srl_cnt <= DEPTH.
  - Never wr while srl_cnt=DEPTH.
  - dout stable while dout_valid & ~dout_ready.

Test Plan:
Common configuration: DWIDTH=8, AWIDTH=4, DEPTH_REDUCTOR=0, AFULL_THRESH=14, so DEPTH=16.
1. Single word: write 0xA5 at cycle 0 with dout_ready=0 -> dout_valid=1 and dout=0xA5 after the 2nd edge; level=1; dout held until dout_ready=1; then empty=1.
2. Fill: write 0x00..0x10 (17 words) with dout_ready=0 -> din_ready drops after the 17th accept; level=17; afull=1 from level=14. Then drain with dout_ready=1 -> reads 0x00..0x10 in order, one per cycle; empty=1 at the end.
3. Streaming: din_valid=1 and dout_ready=1 continuously for 100 words of a counting pattern -> after the 2-cycle fill, one word per cycle; level stays at 1 or 2; data in order.
4. Full plus simultaneous pop: with level=17, hold din_valid=1 and pulse dout_ready for 1 cycle -> din_ready=1 exactly one cycle later; one new word accepted; order preserved.
5. Flush: with level=5, assert flush together with din_valid=1 and dout_ready=1 -> after the edge level=0 and empty=1; that write is dropped. A subsequent write of 0x3C appears 2 cycles later.
6. Async reset: assert arst mid-stream between clock edges -> dout_valid=0, level=0, din_ready=1 immediately; correct operation resumes after release.

Source files
------------

// File: rtl/fpga_srl_fifo.sv
// Shallow elastic FIFO: shift-register (SRL) storage plus a one-entry registered output stage.
// fpga_srl holds the queue body; fpga_srl_fifo sequences its write-enable and read address.

module fpga_srl #(
    parameter int DWIDTH         = 32,
    parameter int AWIDTH         = 5,
    parameter int DEPTH_REDUCTOR = 0
) (
    input  logic              clk,
    input  logic              we,
    input  logic [DWIDTH-1:0] din,
    input  logic [AWIDTH-1:0] addr,
    output logic [DWIDTH-1:0] dout_comb
);
    localparam int DEPTH = 2**AWIDTH - DEPTH_REDUCTOR;

    logic [DWIDTH-1:0] mem [DEPTH];

    // NOTE: the shift chain has no reset so it maps onto SRL primitives; occupancy lives in the controller.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                mem[i] <= mem[i-1];
            end
        end
    end

    generate
        if (DEPTH == 2**AWIDTH) begin : g_full_range
            assign dout_comb = mem[addr];
        end else begin : g_reduced_range
            assign dout_comb = (int'(addr) < DEPTH) ? mem[addr] : '0;
        end
    endgenerate
endmodule

module fpga_srl_fifo #(
    parameter int DWIDTH         = 32,
    parameter int AWIDTH         = 5,
    parameter int DEPTH_REDUCTOR = 0,
    parameter int AFULL_THRESH   = 2**AWIDTH - DEPTH_REDUCTOR - 2
) (
    input  logic              clk,
    input  logic              arst,
    input  logic              flush,
    input  logic [DWIDTH-1:0] din,
    input  logic              din_valid,
    output logic              din_ready,
    output logic [DWIDTH-1:0] dout,
    output logic              dout_valid,
    input  logic              dout_ready,
    output logic [AWIDTH:0]   level,
    output logic              afull,
    output logic              empty
);
    localparam int              DEPTH     = 2**AWIDTH - DEPTH_REDUCTOR;
    localparam int              CW        = AWIDTH + 1;
    localparam logic [AWIDTH:0] DEPTH_CNT = CW'(DEPTH);
    localparam logic [AWIDTH:0] AFULL_LVL = CW'(AFULL_THRESH);

    logic [AWIDTH:0]   srl_cnt;
    logic              out_vld;
    logic              wr;
    logic              pop;
    logic              load;
    logic [AWIDTH-1:0] srl_addr;
    logic [DWIDTH-1:0] srl_dout;

    // Handshake terms depend only on registered state and flush, never on dout_ready.
    assign din_ready = (srl_cnt != DEPTH_CNT) && !flush;
    assign wr        = din_valid && din_ready;
    assign pop       = out_vld && dout_ready;
    assign load      = (srl_cnt != '0) && (!out_vld || pop) && !flush;
    assign srl_addr  = AWIDTH'(srl_cnt - 1'b1);

    fpga_srl #(
        .DWIDTH        (DWIDTH),
        .AWIDTH        (AWIDTH),
        .DEPTH_REDUCTOR(DEPTH_REDUCTOR)
    ) u_srl (
        .clk      (clk),
        .we       (wr),
        .din      (din),
        .addr     (srl_addr),
        .dout_comb(srl_dout)
    );

    // NOTE: all state uses non-blocking assignments so the load samples the SRL head before the same-edge shift.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            srl_cnt <= '0;
            out_vld <= 1'b0;
            dout    <= '0;
        end else if (flush) begin
            srl_cnt <= '0;
            out_vld <= 1'b0;
        end else begin
            case ({wr, load})
                2'b10:   srl_cnt <= srl_cnt + 1'b1;
                2'b01:   srl_cnt <= srl_cnt - 1'b1;
                default: srl_cnt <= srl_cnt;
            endcase
            if (load) begin
                out_vld <= 1'b1;
                dout    <= srl_dout;
            end else if (pop) begin
                out_vld <= 1'b0;
            end
        end
    end

    assign dout_valid = out_vld;
    assign level      = srl_cnt + CW'(out_vld);
    assign afull      = (level >= AFULL_LVL);
    assign empty      = (level == '0);
endmodule

// File: tb/tb_fpga_srl_fifo.sv
// Scoreboard bench for fpga_srl_fifo (DWIDTH=8, AWIDTH=4, DEPTH=16, AFULL_THRESH=14).
// The driver pushes accepted words; a negedge monitor pops and compares on every output handshake.
`timescale 1ns/1ps

module tb_fpga_srl_fifo;
    logic       clk        = 1'b0;
    logic       arst       = 1'b1;
    logic       flush      = 1'b0;
    logic [7:0] din        = 8'h00;
    logic       din_valid  = 1'b0;
    logic       dout_ready = 1'b0;
    logic       din_ready;
    logic [7:0] dout;
    logic       dout_valid;
    logic [4:0] level;
    logic       afull;
    logic       empty;

    int         tests_run    = 0;
    int         tests_failed = 0;
    string      phase        = "reset";
    logic [7:0] sb[$];
    logic       hold_prev    = 1'b0;
    logic [7:0] dout_prev    = 8'h00;

    fpga_srl_fifo #(
        .DWIDTH        (8),
        .AWIDTH        (4),
        .DEPTH_REDUCTOR(0),
        .AFULL_THRESH  (14)
    ) dut (
        .clk       (clk),
        .arst      (arst),
        .flush     (flush),
        .din       (din),
        .din_valid (din_valid),
        .din_ready (din_ready),
        .dout      (dout),
        .dout_valid(dout_valid),
        .dout_ready(dout_ready),
        .level     (level),
        .afull     (afull),
        .empty     (empty)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s/%s: got 0x%0h, expected 0x%0h", phase, name, act, exp);
        end
    endtask

    // Monitor: output handshakes, stall stability and occupancy bound.
    always @(negedge clk) begin
        if (!arst) begin
            check("level_bound", 32'(level <= 5'd17), 32'd1);
            if (hold_prev) begin
                check("hold_valid", 32'(dout_valid), 32'd1);
                check("hold_data", 32'(dout), 32'(dout_prev));
            end
            if (!flush && dout_valid && dout_ready) begin
                check("sb_has_entry", 32'(sb.size() > 0), 32'd1);
                if (sb.size() > 0) check("pop_data", 32'(dout), 32'(sb.pop_front()));
            end
        end
        hold_prev = !arst && !flush && dout_valid && !dout_ready;
        dout_prev = dout;
    end

    // One clock cycle of stimulus; exp_rdy is the hand-derived din_ready for this cycle.
    task automatic cycle(input logic v, input logic [7:0] d, input logic r, input logic f,
                         input logic exp_rdy);
        din_valid  = v;
        din        = d;
        dout_ready = r;
        flush      = f;
        if (f) sb.delete();
        @(negedge clk);
        check("din_ready", 32'(din_ready), 32'(exp_rdy));
        if (v && exp_rdy) sb.push_back(d);
        @(posedge clk);
        #1;
    endtask

    task automatic check_status(input int lvl, input logic vld, input logic af, input logic emp);
        check("level", 32'(level), 32'(lvl));
        check("dout_valid", 32'(dout_valid), 32'(vld));
        check("afull", 32'(afull), 32'(af));
        check("empty", 32'(empty), 32'(emp));
    endtask

    // 17 writes from empty with the consumer stalled; level after write k is 1, then k+1.
    task automatic fill(input logic [7:0] base);
        for (int k = 0; k < 17; k++) begin
            cycle(1'b1, base + 8'(k), 1'b0, 1'b0, 1'b1);
            if (k == 0) check_status(1, 1'b0, 1'b0, 1'b0);
            else        check_status(k + 1, 1'b1, (k + 1) >= 14, 1'b0);
        end
    endtask

    // Consumer always ready, no writes; din_ready of the first cycle is given by the caller.
    task automatic drain(input int n, input int start, input logic first_rdy);
        for (int i = 0; i < n; i++) begin
            cycle(1'b0, 8'h00, 1'b1, 1'b0, (i == 0) ? first_rdy : 1'b1);
            check_status(start - i - 1, (start - i - 1) > 0, (start - i - 1) >= 14,
                         (start - i - 1) == 0);
        end
    endtask

    initial begin
        #200000;
        $display("watchdog expired at %0t", $time);
        $fatal(1, "bench did not finish");
    end

    initial begin
        #12;
        check_status(0, 1'b0, 1'b0, 1'b1);
        check("din_ready", 32'(din_ready), 32'd1);
        check("dout", 32'(dout), 32'h00);
        @(posedge clk);
        #3 arst = 1'b0;

        phase = "t1_single";
        cycle(1'b1, 8'hA5, 1'b0, 1'b0, 1'b1);
        check_status(1, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        check_status(1, 1'b1, 1'b0, 1'b0);
        check("dout", 32'(dout), 32'hA5);
        for (int i = 0; i < 3; i++) cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        check_status(0, 1'b0, 1'b0, 1'b1);

        phase = "t2_fill";
        fill(8'h00);
        cycle(1'b1, 8'h99, 1'b0, 1'b0, 1'b0);
        check_status(17, 1'b1, 1'b1, 1'b0);
        drain(17, 17, 1'b0);

        phase = "t3_stream";
        for (int i = 0; i < 100; i++) begin
            cycle(1'b1, 8'(i * 7 + 3), 1'b1, 1'b0, 1'b1);
            check_status((i == 0) ? 1 : 2, i != 0, 1'b0, 1'b0);
        end
        cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        check_status(1, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        check_status(0, 1'b0, 1'b0, 1'b1);

        phase = "t4_full_pop";
        fill(8'h50);
        cycle(1'b1, 8'hEE, 1'b1, 1'b0, 1'b0);
        check_status(16, 1'b1, 1'b1, 1'b0);
        cycle(1'b1, 8'hEE, 1'b0, 1'b0, 1'b1);
        check_status(17, 1'b1, 1'b1, 1'b0);
        cycle(1'b1, 8'hEF, 1'b0, 1'b0, 1'b0);
        check_status(17, 1'b1, 1'b1, 1'b0);
        drain(17, 17, 1'b0);

        phase = "t5_flush";
        for (int k = 0; k < 5; k++) cycle(1'b1, 8'h20 + 8'(k), 1'b0, 1'b0, 1'b1);
        check_status(5, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 8'h77, 1'b1, 1'b1, 1'b0);
        check_status(0, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, 8'h3C, 1'b0, 1'b0, 1'b1);
        check_status(1, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        check_status(1, 1'b1, 1'b0, 1'b0);
        check("dout", 32'(dout), 32'h3C);
        cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        check_status(0, 1'b0, 1'b0, 1'b1);

        phase = "t6_arst";
        cycle(1'b1, 8'h81, 1'b1, 1'b0, 1'b1);
        cycle(1'b1, 8'h82, 1'b1, 1'b0, 1'b1);
        cycle(1'b1, 8'h83, 1'b1, 1'b0, 1'b1);
        check_status(2, 1'b1, 1'b0, 1'b0);
        din_valid  = 1'b1;
        din        = 8'h84;
        dout_ready = 1'b1;
        #2 arst = 1'b1;
        sb.delete();
        #1;
        check_status(0, 1'b0, 1'b0, 1'b1);
        check("din_ready", 32'(din_ready), 32'd1);
        check("dout", 32'(dout), 32'h00);
        din_valid  = 1'b0;
        dout_ready = 1'b0;
        @(posedge clk);
        #3 arst = 1'b0;
        cycle(1'b1, 8'h3D, 1'b0, 1'b0, 1'b1);
        check_status(1, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 8'h3E, 1'b0, 1'b0, 1'b1);
        check_status(2, 1'b1, 1'b0, 1'b0);
        check("dout", 32'(dout), 32'h3D);
        drain(2, 2, 1'b1);

        phase = "end";
        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
